// File: rtl/dsram_bus_responder_pkg.sv
// Shared definitions for the data-SRAM bus responder.
//   state_t            : access sequencer states (IDLE/REQ/RESP/DONE)
//   BYTE_W             : bits per byte lane / write strobe
//   TIMEOUT_RDATA_BIT  : fill bit for load data forced on a bus timeout
//   tmo_cnt_width()    : width of a counter that can hold 0..timeout
package dsram_bus_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int BYTE_W = 8;

  localparam logic TIMEOUT_RDATA_BIT = 1'b0;

  function automatic int tmo_cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/dsram_req_reg.sv
// Capture/hold register for one memory request (address, store data,
// byte strobes, write flag). Loaded when an access is accepted from EX and
// then held stable while the request sits on the bus. When posted writes
// are enabled this same register is the single-entry store buffer.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   load                capture the incoming access this cycle
//   addr, wdata, wstrb  access fields from EX
//   held_addr/wdata/wstrb/we  registered request fields driven onto the bus
module dsram_req_reg
  import dsram_bus_responder_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/BYTE_W-1:0] wstrb,
  output logic [ADDR_W-1:0]        held_addr,
  output logic [DATA_W-1:0]        held_wdata,
  output logic [DATA_W/BYTE_W-1:0] held_wstrb,
  output logic                     held_we
);

  always_ff @(posedge clk) begin
    if (rst) begin
      held_addr  <= '0;
      held_wdata <= '0;
      held_wstrb <= '0;
      held_we    <= 1'b0;
    end else if (load) begin
      held_addr  <= addr;
      held_wdata <= wdata;
      held_wstrb <= wstrb;
      // Any non-zero strobe pattern is a store; strobes pass through as-is.
      held_we    <= |wstrb;
    end
  end

endmodule

// File: rtl/dsram_bus_responder.sv
// Responder for the EX-stage data-SRAM port. Each access becomes one
// valid/ready request plus one single-cycle response on the external bus.
// The pipeline is stalled until the DONE cycle, in which it advances;
// load data is registered and held until the next load completes.
// A bus that never answers is cut off after TIMEOUT cycles in REQ+RESP:
// the access is force-completed, loads return zero and bus_err latches.
// Optional build macro DSRAM_POSTED_WRITE_EN: a store seen in IDLE is
// accepted without stalling and drains in the background; any access that
// arrives meanwhile stalls until the drain finishes.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   data_sram_en/wen/addr/wdata  access from EX (wen == 0 means load)
//   data_sram_rdata          registered load data for MEM
//   stallreq_from_mem        combinational pipeline stall request
//   bus_req_valid/ready/we/wstrb/addr/wdata  request channel
//   bus_resp_valid/rdata     response channel (single-cycle ack)
//   bus_err                  sticky timeout flag
module dsram_bus_responder
  import dsram_bus_responder_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     data_sram_en,
  input  logic [DATA_W/BYTE_W-1:0] data_sram_wen,
  input  logic [ADDR_W-1:0]        data_sram_addr,
  input  logic [DATA_W-1:0]        data_sram_wdata,
  output logic [DATA_W-1:0]        data_sram_rdata,
  output logic                     stallreq_from_mem,
  output logic                     bus_req_valid,
  input  logic                     bus_req_ready,
  output logic                     bus_req_we,
  output logic [DATA_W/BYTE_W-1:0] bus_req_wstrb,
  output logic [ADDR_W-1:0]        bus_req_addr,
  output logic [DATA_W-1:0]        bus_req_wdata,
  input  logic                     bus_resp_valid,
  input  logic [DATA_W-1:0]        bus_resp_rdata,
  output logic                     bus_err
);

  localparam int CNT_W = tmo_cnt_width(TIMEOUT);
  // Value of the counter during the last permitted REQ/RESP cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

`ifdef DSRAM_POSTED_WRITE_EN
  localparam logic POSTED_WRITE = 1'b1;
`else
  localparam logic POSTED_WRITE = 1'b0;
`endif

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              req_valid_reg;
  logic              err_reg;
  logic              posted_reg;   // current access is a background store drain
  logic [DATA_W-1:0] rdata_reg;

  logic   is_store;
  logic   capture;
  logic   busy;
  logic   tmo_hit;
  state_t finish_state;

  assign is_store = |data_sram_wen;
  assign capture  = (state_reg == ST_IDLE) && data_sram_en;
  assign busy     = (state_reg == ST_REQ) || (state_reg == ST_RESP);
  assign tmo_hit  = busy && (cnt_reg == CNT_LAST);
  // A posted drain has no stalled instruction waiting on it, so it skips
  // DONE: passing through DONE would release whatever access is now
  // stalled behind the drain without that access ever being issued.
  assign finish_state = posted_reg ? ST_IDLE : ST_DONE;

  dsram_req_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_req_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (capture),
    .addr       (data_sram_addr),
    .wdata      (data_sram_wdata),
    .wstrb      (data_sram_wen),
    .held_addr  (bus_req_addr),
    .held_wdata (bus_req_wdata),
    .held_wstrb (bus_req_wstrb),
    .held_we    (bus_req_we)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      req_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
      posted_reg    <= 1'b0;
      rdata_reg     <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          cnt_reg <= '0;
          if (data_sram_en) begin
            state_reg     <= ST_REQ;
            req_valid_reg <= 1'b1;
            posted_reg    <= POSTED_WRITE && is_store;
          end
        end
        ST_REQ: begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (tmo_hit) begin
            req_valid_reg <= 1'b0;
            err_reg       <= 1'b1;
            if (!bus_req_we) rdata_reg <= {DATA_W{TIMEOUT_RDATA_BIT}};
            posted_reg    <= 1'b0;
            state_reg     <= finish_state;
          end else if (bus_req_ready) begin
            req_valid_reg <= 1'b0;
            state_reg     <= ST_RESP;
          end
        end
        ST_RESP: begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          // A real response in the final cycle still counts as success.
          if (bus_resp_valid) begin
            if (!bus_req_we) rdata_reg <= bus_resp_rdata;
            posted_reg <= 1'b0;
            state_reg  <= finish_state;
          end else if (tmo_hit) begin
            err_reg    <= 1'b1;
            if (!bus_req_we) rdata_reg <= {DATA_W{TIMEOUT_RDATA_BIT}};
            posted_reg <= 1'b0;
            state_reg  <= finish_state;
          end
        end
        ST_DONE: begin
          cnt_reg   <= '0;
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // The pipeline advances only in DONE; with posted writes a store that
  // finds the buffer empty (IDLE) is also released immediately.
  assign stallreq_from_mem = data_sram_en && (state_reg != ST_DONE) &&
                             !(POSTED_WRITE && (state_reg == ST_IDLE) && is_store);

  assign bus_req_valid   = req_valid_reg;
  assign bus_err         = err_reg;
  assign data_sram_rdata = rdata_reg;

endmodule
